fp_divider: RTL
===============

Name: fp_divider

Overview:
- Iterative IEEE-754 single-precision divider, res = num1 / num2; the inverse companion of fp_multiplier, sharing its operand/result/valid interface style.
- Produces one restoring-division quotient bit per cycle.
- Special operands are resolved in a fast path.
- Sits beside fp_multiplier in the FP datapath; one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MANT_W, 23, stored mantissa width; iteration count N = MANT_W+4 (27 at default).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  start request, sampled only when busy=0
- num1  input  1+EXP_W+MANT_W  dividend
- num2  input  1+EXP_W+MANT_W  divisor
- res  output  1+EXP_W+MANT_W  quotient, held until next result
- val  output  1  one-cycle pulse, res valid
- busy  output  1  high from the cycle after acceptance until the val cycle
- dz  output  1  divide-by-zero flag, valid with val, held with res

Behaviour:
- Reset: res=0, val=0, busy=0, dz=0, state=IDLE. Reset mid-operation aborts the division; no val follows.
- States and transitions:
  - IDLE: on en, register operands; go to SPECIAL_OUT if special, else DIVIDE.
  - DIVIDE: exactly N cycles.
  - ROUND: 1 cycle.
  - DONE: val=1 for one cycle, then IDLE.
  - SPECIAL_OUT: val=1 next cycle, then IDLE.
- Latency (en sampled at edge T): normal ops give val at edge T+N+2 (T+29 default); specials give val at T+1.
- en while busy=1 is ignored. en in the DONE cycle is ignored. en in IDLE immediately after DONE is accepted.
- sign = s1 XOR s2 for all results, except NaN, which is positive.
- Inputs with exp==0 (zero/denormal) are treated as signed zero.
- Special priority:
  1. Either NaN -> 0x7FC00000.
  2. 0/0 or inf/inf -> 0x7FC00000.
  3. x/0 (x finite nonzero) -> signed inf, dz=1.
  4. inf/x -> signed inf.
  5. x/inf or 0/x -> signed zero.
- dz=0 for every result except case 3.
- Datapath: ma={1,mant1}, mb={1,mant2}. Compute q = floor(ma*2^(N-1)/mb), N bits, plus remainder rem.
- If ma>=mb:
  - q[N-1]=1, mantissa = q[N-2:3].
  - guard = q[2]; sticky = |q[1:0] OR rem!=0.
  - exp = e1-e2+bias.
- Else:
  - mantissa = q[N-3:2].
  - guard = q[1]; sticky = q[0] OR rem!=0.
  - exp = e1-e2+bias-1.
- Exponent arithmetic is signed, EXP_W+2 bits, no wrap.
- Rounding carry out of the mantissa: mantissa=0, exp+1.
- Range limits, checked after rounding:
  - exp >= 2^EXP_W-1 -> signed inf (dz=0).
  - exp <= 0 -> signed zero (flush, no denormals).

Optional Feature:
- Macro FP_DIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even in ROUND. Increment the mantissa when guard AND (sticky OR mantissa LSB).
- Undefined: truncation (round toward zero). guard/sticky are ignored; ROUND still takes 1 cycle, so latency is identical.

Test Plan:
- Exact quotient: 0x40C00000 / 0x40000000 (6.0/2.0) -> res=0x40400000, dz=0, val exactly at T+29, busy high T+1..T+29.
- Rounding: 0x3F800000 / 0x40400000 (1/3):
  - with macro -> 0x3EAAAAAB;
  - without -> 0x3EAAAAAA.
  - Sign case: 0xBF800000 / 0x40400000 -> 0xBEAAAAAB (with macro).
- Specials, each with val at T+1:
  - 0x3F800000/0x00000000 -> 0x7F800000, dz=1.
  - 0x00000000/0x00000000 -> 0x7FC00000, dz=0.
  - 0x7F800000/0x7F800000 -> 0x7FC00000.
  - 0x7FC00001/0x3F800000 -> 0x7FC00000.
  - 0x40000000/0xFF800000 -> 0x80000000.
- Range limits:
  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000.
  - 0x00800000 / 0x40000000 -> 0x00000000.
  - 0x00400000 (denormal) / 0x3F800000 -> 0x00000000.
- Handshake: en pulsed at T+5 and at T+29 during an operation -> ignored, exactly one val. en at T+30 -> accepted, second val at T+59.
- Reset: rst asserted at T+10 for one cycle -> val, busy, res, dz all 0 next cycle, no val afterwards. A new en then produces a correct result.

Source files
------------

// File: rtl/fp_divider.sv
// Iterative IEEE-754 single-precision divider: one restoring quotient bit per cycle, fast path for specials.
// Define FP_DIV_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module fp_divider #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [EXP_W+MANT_W:0] num1,
    input  logic [EXP_W+MANT_W:0] num2,
    output logic [EXP_W+MANT_W:0] res,
    output logic                  val,
    output logic                  busy,
    output logic                  dz
);
    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int N  = MANT_W + 4;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(N);

    localparam logic [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DIVIDE  = 3'd1;
    localparam logic [2:0] S_ROUND   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_SPECIAL = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic [XW-1:0]     exp_q, exp_d;
    logic [MANT_W:0]   mb_q, mb_d;
    logic [MANT_W+1:0] rem_q, rem_d;
    logic [N-1:0]      quot_q, quot_d;
    logic [W-1:0]      pend_q, pend_d;
    logic              pend_dz_q, pend_dz_d;
    logic [W-1:0]      res_q, res_d;
    logic              val_q, val_d;
    logic              dz_q, dz_d;

    logic              s1, s2;
    logic [EXP_W-1:0]  e1, e2;
    logic [MANT_W-1:0] m1, m2;
    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    assign s1 = num1[W-1];
    assign s2 = num2[W-1];
    assign e1 = num1[W-2:MANT_W];
    assign e2 = num2[W-2:MANT_W];
    assign m1 = num1[MANT_W-1:0];
    assign m2 = num2[MANT_W-1:0];

    // Denormals have exp==0 and are deliberately folded into zero.
    assign a_zero = ~|e1;
    assign b_zero = ~|e2;
    assign a_nan  = (&e1) & (|m1);
    assign b_nan  = (&e2) & (|m2);
    assign a_inf  = (&e1) & ~(|m1);
    assign b_inf  = (&e2) & ~(|m2);

    logic              ge;
    logic [MANT_W+1:0] rem_sel;
    logic              norm;
    logic [MANT_W-1:0] mant;
    logic [XW-1:0]     exp_n, exp_r;
    logic              inc;
    logic [MANT_W:0]   mant_r;
`ifdef FP_DIV_ROUND_NEAREST_EN
    logic              guard, sticky;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mb_d      = mb_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        pend_d    = pend_q;
        pend_dz_d = pend_dz_q;
        res_d     = res_q;
        dz_d      = dz_q;
        val_d     = 1'b0;

        ge      = rem_q >= {1'b0, mb_q};
        rem_sel = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        norm    = quot_q[N-1];
        mant    = norm ? quot_q[N-2:3] : quot_q[N-3:2];
        exp_n   = norm ? exp_q : exp_q - XW'(1);
`ifdef FP_DIV_ROUND_NEAREST_EN
        guard   = norm ? quot_q[2] : quot_q[1];
        sticky  = (norm ? |quot_q[1:0] : quot_q[0]) | (|rem_q);
        inc     = guard & (sticky | mant[0]);
`else
        inc     = 1'b0;
`endif
        // A carry out leaves the low mantissa bits all zero, so only the exponent needs a bump.
        mant_r  = {1'b0, mant} + {{MANT_W{1'b0}}, inc};
        exp_r   = mant_r[MANT_W] ? exp_n + XW'(1) : exp_n;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    sign_d    = s1 ^ s2;
                    exp_d     = {2'b00, e1} - {2'b00, e2} + BIAS;
                    mb_d      = {1'b1, m2};
                    rem_d     = {2'b01, m1};
                    quot_d    = '0;
                    cnt_d     = '0;
                    pend_dz_d = 1'b0;
                    state_d   = S_SPECIAL;
                    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
                        pend_d = QNAN;
                    end else if (a_inf) begin
                        pend_d = {s1 ^ s2, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                    end else if (b_zero) begin
                        pend_d    = {s1 ^ s2, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        pend_dz_d = 1'b1;
                    end else if (b_inf | a_zero) begin
                        pend_d = {s1 ^ s2, {(W-1){1'b0}}};
                    end else begin
                        state_d = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                quot_d = {quot_q[N-2:0], ge};
                rem_d  = rem_sel << 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                pend_dz_d = 1'b0;
                if ($signed(exp_r) >= $signed(EXP_MAX)) begin
                    pend_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                end else if (exp_r[XW-1] || exp_r == '0) begin
                    pend_d = {sign_q, {(W-1){1'b0}}};
                end else begin
                    pend_d = {sign_q, exp_r[EXP_W-1:0], mant_r[MANT_W-1:0]};
                end
                state_d = S_DONE;
            end
            S_DONE, S_SPECIAL: begin
                res_d   = pend_q;
                dz_d    = pend_dz_q;
                val_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            val_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            val_q   <= val_d;
            dz_q    <= dz_d;
        end
    end

    // NOTE: datapath registers are left unreset; each is loaded on acceptance before it is ever read.
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        sign_q    <= sign_d;
        exp_q     <= exp_d;
        mb_q      <= mb_d;
        rem_q     <= rem_d;
        quot_q    <= quot_d;
        pend_q    <= pend_d;
        pend_dz_q <= pend_dz_d;
    end

    assign res  = res_q;
    assign val  = val_q;
    assign dz   = dz_q;
    assign busy = (state_q != S_IDLE);

endmodule
